// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Shared constants for the framebuffer write path: framebuffer geometry,
// common colours, requester slot assignments, the arbiter state type and a
// small helper that advances a round-robin index.
// No ports (package).
// ---------------------------------------------------------------------------
package vram_pkg;

  localparam int H_LEN    = 200;
  localparam int V_LEN    = 150;
  localparam int FB_DEPTH = H_LEN * V_LEN;

  // Width of a requester index; owner/rr pointer are carried at this width.
  localparam int OWNER_W = 2;

  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hfff;

  localparam int REQ_INIT   = 0;
  localparam int REQ_STAMP  = 1;
  localparam int REQ_CURSOR = 2;
  localparam int REQ_RESET  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index following idx, wrapping back to 0 after the last requester.
  function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                 input int nreq);
    return (int'(idx) == nreq - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/vram_write_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// ptr and wrapping at NREQ; reports the first requester found.
//   req   in  NREQ     request vector
//   ptr   in  OWNER_W  index to start the search from
//   win   out OWNER_W  index of the chosen requester (0 when none)
//   found out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick
  import vram_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] win,
  output logic               found
);

  logic [OWNER_W:0] idx;

  // The extra index bit keeps ptr+i from overflowing before the wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (OWNER_W + 1)'(i);
      if (idx >= (OWNER_W + 1)'(NREQ)) begin
        idx = idx - (OWNER_W + 1)'(NREQ);
      end
      if (!found && req[idx[OWNER_W-1:0]]) begin
        found = 1'b1;
        win   = idx[OWNER_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// vram_write_arbiter
// Shares the single framebuffer write port among the drawing engines. One
// engine is granted at a time in round-robin order and keeps the grant until
// its last beat is accepted. Accepted beats appear on we/waddr/wdata one
// cycle later.
//
// Optional feature: define VRAM_ARB_BOUNDS_EN to drop beats whose address is
// at or beyond the framebuffer depth (beat still accepted, no write, err_oob
// pulses instead). Without it every accepted beat is written.
//
// Ports:
//   clk, rstn             clock; synchronous active-low reset
//   req_valid/req_last    per-requester beat valid / final beat of packet
//   req_addr/req_data     per-requester beat address / colour, packed
//   req_ready             beat accepted this cycle
//   we/waddr/wdata        framebuffer write port (registered)
//   busy                  a grant is held
//   owner                 current or most recent grantee
//   err_oob               out-of-bounds beat dropped (single-cycle pulse)
// ---------------------------------------------------------------------------
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 15,
  parameter int CW    = 12,
  parameter int H_LEN = vram_pkg::H_LEN,
  parameter int V_LEN = vram_pkg::V_LEN
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DW-1:0]   req_addr,
  input  logic [NREQ*CW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 we,
  output logic [DW-1:0]        waddr,
  output logic [CW-1:0]        wdata,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner,
  output logic                 err_oob
);

  localparam logic [DW-1:0] FB_LIMIT = DW'(H_LEN * V_LEN);

  arb_state_e          state_q, state_d;
  logic [OWNER_W-1:0]  owner_q, owner_d;
  logic [OWNER_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       waddr_q, waddr_d;
  logic [CW-1:0]       wdata_q, wdata_d;
  logic                err_oob_q, err_oob_d;

  logic [DW-1:0]       addr_arr [NREQ];
  logic [CW-1:0]       data_arr [NREQ];
  logic [OWNER_W-1:0]  pick_win;
  logic                pick_found;
  logic [DW-1:0]       sel_addr;
  logic [CW-1:0]       sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                oob;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_arr[k] = req_addr[k*DW +: DW];
    assign data_arr[k] = req_data[k*CW +: CW];
  end

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .win   (pick_win),
    .found (pick_found)
  );

  assign sel_addr  = addr_arr[owner_q];
  assign sel_data  = data_arr[owner_q];
  assign sel_valid = req_valid[owner_q];
  assign sel_last  = req_last[owner_q];
  assign oob       = (sel_addr >= FB_LIMIT);

`ifdef VRAM_ARB_BOUNDS_EN
`else
  logic unused_oob;
  assign unused_oob = oob;
`endif

  // Arbitration in IDLE costs one cycle; in GRANT only the owner sees ready,
  // and the owner dropping valid simply stalls the packet with no write.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_oob_d = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        req_ready[owner_q] = sel_valid;
        if (sel_valid) begin
          waddr_d = sel_addr;
          wdata_d = sel_data;
`ifdef VRAM_ARB_BOUNDS_EN
          we_d      = !oob;
          err_oob_d = oob;
`else
          we_d      = 1'b1;
`endif
          if (sel_last) begin
            rr_ptr_d = rr_next(owner_q, NREQ);
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      err_oob_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      err_oob_q <= err_oob_d;
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign busy    = (state_q == GRANT);
  assign owner   = owner_q;
  assign err_oob = err_oob_q;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_write_arbiter
// Self-checking bench for vram_write_arbiter: a fixed vector table, directed
// multi-cycle sequences and a randomized run, all checked against a
// behavioural model of the arbitration rules. Honours VRAM_ARB_BOUNDS_EN.
// ---------------------------------------------------------------------------
module tb_vram_write_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 15;
  localparam int CW    = 12;
  localparam int DEPTH = 200 * 150;

  logic                clk;
  logic                rstn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_last;
  logic [NREQ*DW-1:0]  req_addr;
  logic [NREQ*CW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                we;
  logic [DW-1:0]       waddr;
  logic [CW-1:0]       wdata;
  logic                busy;
  logic [1:0]          owner;
  logic                err_oob;

  vram_write_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .H_LEN(200), .V_LEN(150)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .owner     (owner),
    .err_oob   (err_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: who holds the port, where the next search starts,
  // and what the write port should show this cycle.
  bit            m_grant;
  int            m_owner;
  int            m_ptr;
  bit            m_we;
  bit            m_err;
  logic [DW-1:0] m_waddr;
  logic [CW-1:0] m_wdata;

  // Stimulus plan per requester.
  int            left   [NREQ];
  int            reload [NREQ];
  int            plen   [NREQ];
  int            pause  [NREQ];
  logic [DW-1:0] a      [NREQ];
  logic [DW-1:0] stp    [NREQ];
  logic [CW-1:0] d      [NREQ];

  int order_q[$];
  bit prev_busy;
  int n_we;
  int n_err;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
    logic [DW-1:0]   addr;
    logic [CW-1:0]   data;
    logic [NREQ-1:0] exp_ready;
    logic            exp_busy;
    logic [1:0]      exp_owner;
    logic            exp_we;
    logic [DW-1:0]   exp_waddr;
    logic [CW-1:0]   exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_grant && req_valid[m_owner]) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_owner = 0; m_ptr = 0;
    m_we = 0; m_err = 0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic model_update(input logic [NREQ-1:0] rdy);
    logic [DW-1:0] ad;
    bit            hit;
    if (!rstn) begin
      model_reset();
    end else if (!m_grant) begin
      m_we = 0; m_err = 0; hit = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!hit && req_valid[(m_ptr + k) % NREQ]) begin
          hit = 1; m_owner = (m_ptr + k) % NREQ; m_grant = 1;
        end
      end
    end else begin
      m_we = 0; m_err = 0;
      if (rdy[m_owner]) begin
        ad = req_addr[m_owner*DW +: DW];
`ifdef VRAM_ARB_BOUNDS_EN
        m_we  = (int'(ad) < DEPTH);
        m_err = !(int'(ad) < DEPTH);
`else
        m_we  = 1;
`endif
        m_waddr = ad;
        m_wdata = req_data[m_owner*CW +: CW];
        if (req_last[m_owner]) begin
          m_ptr   = (m_owner + 1) % NREQ;
          m_grant = 0;
        end
      end
    end
  endtask

  task automatic clear_plans();
    for (int k = 0; k < NREQ; k++) begin
      left[k] = 0; reload[k] = 0; plen[k] = 2; pause[k] = 0;
      a[k] = '0; stp[k] = DW'(1); d[k] = CW'($urandom);
    end
  endtask

  task automatic applyStimulus();
    for (int k = 0; k < NREQ; k++) begin
      req_valid[k]           = (left[k] > 0) && (pause[k] == 0);
      req_last[k]            = (left[k] == 1);
      req_addr[k*DW +: DW]   = a[k];
      req_data[k*CW +: CW]   = d[k];
    end
  endtask

  task automatic checkOutput(input logic [NREQ-1:0] rdy);
    check("req_ready", 32'(req_ready), 32'(rdy));
    check("busy", 32'(busy), 32'(m_grant));
    check("owner", 32'(owner), m_owner);
    check("we", 32'(we), 32'(m_we));
    check("err_oob", 32'(err_oob), 32'(m_err));
    if (m_we) begin
      check("waddr", 32'(waddr), 32'(m_waddr));
      check("wdata", 32'(wdata), 32'(m_wdata));
    end
  endtask

  // One clock: drive plan, compare at negedge, advance model and plan.
  task automatic step();
    logic [NREQ-1:0] rdy;
    applyStimulus();
    @(negedge clk);
    rdy = model_ready();
    checkOutput(rdy);
    if (busy === 1'b1 && !prev_busy) order_q.push_back(int'(owner));
    prev_busy = (busy === 1'b1);
    if (we === 1'b1) n_we++;
    if (err_oob === 1'b1) n_err++;
    @(posedge clk);
    model_update(rdy);
    for (int k = 0; k < NREQ; k++) begin
      if (rstn && rdy[k]) begin
        left[k]--;
        a[k] = a[k] + stp[k];
        d[k] = CW'($urandom);
        if (left[k] == 0 && reload[k] > 0) begin
          reload[k]--;
          left[k] = plen[k];
        end
      end
      if (pause[k] > 0) pause[k]--;
    end
    #1;
  endtask

  function automatic bit pending();
    bit p;
    p = m_grant;
    for (int k = 0; k < NREQ; k++) if (left[k] > 0) p = 1;
    return p;
  endfunction

  task automatic run_until_idle(input int maxc);
    int c;
    c = 0;
    while (pending() && c < maxc) begin
      step();
      c++;
    end
    step();
    check("drain_pending", 32'(pending()), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_plans();
    applyStimulus();
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 0);
    check("rst we", 32'(we), 0);
    check("rst waddr", 32'(waddr), 0);
    check("rst wdata", 32'(wdata), 0);
    check("rst busy", 32'(busy), 0);
    check("rst owner", 32'(owner), 0);
    check("rst err_oob", 32'(err_oob), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    prev_busy = 0;
    order_q.delete();
    n_we = 0;
    n_err = 0;
  endtask

  task automatic check_order(input string tag, input int n, input int exp[5]);
    check({tag, " grants"}, 32'(order_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s grant%0d", tag, i),
            (i < order_q.size()) ? 32'(order_q[i]) : 32'hffff_ffff, 32'(exp[i]));
    end
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;

    // valid, last, addr, data | ready, busy, owner, we, waddr, wdata
    vecs[0]  = '{4'b0010, 4'b0000, 15'd1005, 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0, 15'd0,    12'h000};
    vecs[1]  = '{4'b0010, 4'b0000, 15'd1005, 12'h000, 4'b0010, 1'b1, 2'd1, 1'b0, 15'd0,    12'h000};
    vecs[2]  = '{4'b0010, 4'b0000, 15'd1006, 12'h000, 4'b0010, 1'b1, 2'd1, 1'b1, 15'd1005, 12'h000};
    vecs[3]  = '{4'b0010, 4'b0010, 15'd1007, 12'h000, 4'b0010, 1'b1, 2'd1, 1'b1, 15'd1006, 12'h000};
    vecs[4]  = '{4'b0000, 4'b0000, 15'd0,    12'h000, 4'b0000, 1'b0, 2'd1, 1'b1, 15'd1007, 12'h000};
    vecs[5]  = '{4'b0000, 4'b0000, 15'd0,    12'h000, 4'b0000, 1'b0, 2'd1, 1'b0, 15'd0,    12'h000};
    vecs[6]  = '{4'b1010, 4'b1010, 15'd500,  12'hfff, 4'b0000, 1'b0, 2'd1, 1'b0, 15'd0,    12'h000};
    vecs[7]  = '{4'b1010, 4'b1010, 15'd500,  12'hfff, 4'b1000, 1'b1, 2'd3, 1'b0, 15'd0,    12'h000};
    vecs[8]  = '{4'b0010, 4'b0010, 15'd500,  12'hfff, 4'b0000, 1'b0, 2'd3, 1'b1, 15'd500,  12'hfff};
    vecs[9]  = '{4'b0010, 4'b0010, 15'd500,  12'hfff, 4'b0010, 1'b1, 2'd1, 1'b0, 15'd0,    12'h000};
    vecs[10] = '{4'b0000, 4'b0000, 15'd0,    12'h000, 4'b0000, 1'b0, 2'd1, 1'b1, 15'd500,  12'hfff};
    vecs[11] = '{4'b0000, 4'b0000, 15'd0,    12'h000, 4'b0000, 1'b0, 2'd1, 1'b0, 15'd0,    12'h000};

    // Vector table: requester 1 three-beat packet, then pointer at 2 favours 3 over 1.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_valid = vecs[i].valid;
      req_last  = vecs[i].last;
      req_addr  = {NREQ{vecs[i].addr}};
      req_data  = {NREQ{vecs[i].data}};
      @(negedge clk);
      check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d owner", i), 32'(owner), 32'(vecs[i].exp_owner));
      check($sformatf("vec%0d we", i), 32'(we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vecs[i].exp_waddr));
        check($sformatf("vec%0d wdata", i), 32'(wdata), 32'(vecs[i].exp_wdata));
      end
      @(posedge clk);
      #1;
    end

    // All four requesting 2-beat packets, requester 0 returns with a second one.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      left[k] = 2; plen[k] = 2; a[k] = DW'(1000 * (k + 1));
    end
    reload[0] = 1;
    run_until_idle(100);
    check_order("rr4", 5, '{0, 1, 2, 3, 0});
    check("rr4 writes", 32'(n_we), 10);

    // Owner 2 stalls three cycles mid-packet while requester 0 waits.
    do_reset();
    left[2] = 4; a[2] = DW'(2000);
    step();
    step();
    pause[2] = 3;
    left[0]  = 1; a[0] = DW'(100);
    run_until_idle(100);
    check_order("stall", 2, '{2, 0, 0, 0, 0});
    check("stall writes", 32'(n_we), 5);

    // Boundary: 30000 then 29999 from requester 1.
    do_reset();
    left[1] = 2; a[1] = DW'(30000); stp[1] = '1;
    run_until_idle(50);
`ifdef VRAM_ARB_BOUNDS_EN
    check("oob writes", 32'(n_we), 1);
    check("oob errors", 32'(n_err), 1);
`else
    check("oob writes", 32'(n_we), 2);
    check("oob errors", 32'(n_err), 0);
`endif

    // Reset in beat 2 of a 5-beat packet with the pointer sitting at 2.
    do_reset();
    left[1] = 1; a[1] = DW'(300);
    run_until_idle(50);
    left[0] = 5; a[0] = DW'(4000);
    step();
    step();
    rstn = 1'b0;
    step();
    clear_plans();
    applyStimulus();
    @(negedge clk);
    check("midrst we", 32'(we), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    order_q.delete();
    prev_busy = 0;
    left[1] = 1; a[1] = DW'(700);
    left[3] = 1; a[3] = DW'(900);
    run_until_idle(50);
    check_order("midrst", 2, '{1, 3, 0, 0, 0});

    // Single-beat packets from 0 and 1 together right after reset.
    do_reset();
    left[0] = 1; a[0] = DW'(10);
    left[1] = 1; a[1] = DW'(20);
    run_until_idle(50);
    check_order("single", 2, '{0, 1, 0, 0, 0});
    check("single writes", 32'(n_we), 2);

    // Randomized traffic with owner stalls and addresses near the boundary.
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (left[k] == 0 && $urandom_range(0, 3) == 0) begin
          left[k] = $urandom_range(1, 4);
          a[k] = ($urandom_range(0, 7) == 0) ? DW'(29995 + $urandom_range(0, 10))
                                             : DW'($urandom_range(0, 29000));
          d[k] = CW'($urandom);
        end
        if (m_grant && m_owner == k && left[k] > 0 && pause[k] == 0 &&
            $urandom_range(0, 7) == 0) begin
          pause[k] = $urandom_range(1, 2);
        end
      end
      step();
    end
    run_until_idle(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
